tt_sweep: RTL and testbench

TT_SWEEP -- requirements
Module: tt_sweep

---
 rtl/tt_sweep.sv | 139 +++++++++++++
 tb/tb_tt_sweep.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep.sv
// tt_sweep: walks all 128 input vectors of a 7-input function under test,
// gathers the returned output bits into a truth table and counts the onset.
// Results are held under a valid/ready handshake until the consumer takes them.
module tt_sweep #(
  parameter int LAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic [6:0]   x_out,
  output logic         x_valid,
  input  logic         f_in,
  output logic [127:0] tt,
  output logic [7:0]   ones,
  output logic         tt_valid,
  input  logic         tt_ready
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t         state_q;
  logic           busy_q;
  logic [6:0]     x_out_q;
  logic           x_valid_q;
  logic [127:0]   tt_q;
  logic [7:0]     ones_q;
  logic           tt_valid_q;
  logic [2:0]     drain_q;

  logic [6:0]     x_out_d;
  logic [7:0]     ones_d;
  logic           cap_vld;
  logic [6:0]     cap_idx;

  // Next vector index and the onset count after a possible capture.
  always_comb begin
    x_out_d = x_out_q + 7'd1;
    ones_d  = ones_q + {7'd0, f_in};
  end

  generate
    if (LAT == 0) begin : g_direct
      // With no latency the function answers in the cycle its vector is shown.
      assign cap_vld = x_valid_q;
      assign cap_idx = x_out_q;
    end else begin : g_dly
      logic       vld_q [LAT];
      logic [6:0] idx_q [LAT];

      // Tag delay line: carries each issued index until its answer is due.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < LAT; i++) vld_q[i] <= 1'b0;
        end else begin
          vld_q[0] <= x_valid_q;
          for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
        end
        idx_q[0] <= x_out_q;
        for (int i = 1; i < LAT; i++) idx_q[i] <= idx_q[i-1];
      end

      assign cap_vld = vld_q[LAT-1];
      assign cap_idx = idx_q[LAT-1];
    end
  endgenerate

  // Control FSM with registered outputs; captures land whenever a tag is due.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      x_out_q    <= 7'd0;
      x_valid_q  <= 1'b0;
      tt_q       <= '0;
      ones_q     <= 8'd0;
      tt_valid_q <= 1'b0;
      drain_q    <= 3'd0;
    end else begin
      if (cap_vld) begin
        tt_q[cap_idx] <= f_in;
        ones_q        <= ones_d;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= SWEEP;
            busy_q    <= 1'b1;
            x_out_q   <= 7'd0;
            x_valid_q <= 1'b1;
            tt_q      <= '0;
            ones_q    <= 8'd0;
          end
        end
        SWEEP: begin
          if (x_out_q == 7'd127) begin
            x_out_q   <= 7'd0;
            x_valid_q <= 1'b0;
            drain_q   <= 3'd0;
            if (LAT == 0) begin
              state_q    <= DONE;
              busy_q     <= 1'b0;
              tt_valid_q <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end else begin
            x_out_q <= x_out_d;
          end
        end
        DRAIN: begin
          // The last tag is captured on the same edge that enters DONE.
          if (drain_q == 3'(LAT - 1)) begin
            state_q    <= DONE;
            busy_q     <= 1'b0;
            tt_valid_q <= 1'b1;
          end else begin
            drain_q <= drain_q + 3'd1;
          end
        end
        DONE: begin
          if (tt_ready) begin
            state_q    <= IDLE;
            tt_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign x_out    = x_out_q;
  assign x_valid  = x_valid_q;
  assign tt       = tt_q;
  assign ones     = ones_q;
  assign tt_valid = tt_valid_q;

endmodule

// File: tb/tb_tt_sweep.sv
// Bench for tt_sweep: two instances (LAT=0 and LAT=3) each drive a function
// under test defined as a 128-entry table; results are scoreboarded.
module tb_tt_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   rst, start, busy, x_valid, f_in, tt_valid, tt_ready;
  logic [6:0]   x_out [2];
  logic [127:0] tt [2];
  logic [7:0]   ones [2];

  tt_sweep #(.LAT(0)) dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .busy(busy[0]),
    .x_out(x_out[0]), .x_valid(x_valid[0]), .f_in(f_in[0]), .tt(tt[0]),
    .ones(ones[0]), .tt_valid(tt_valid[0]), .tt_ready(tt_ready[0]));

  tt_sweep #(.LAT(3)) dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .busy(busy[1]),
    .x_out(x_out[1]), .x_valid(x_valid[1]), .f_in(f_in[1]), .tt(tt[1]),
    .ones(ones[1]), .tt_valid(tt_valid[1]), .tt_ready(tt_ready[1]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Function under test: table lookup, answered 0 or 3 cycles later;
  // random junk whenever no vector is due.
  logic [127:0] F [2];
  logic         junk;
  logic         hv [3];
  logic [6:0]   hx [3];
  always @(posedge clk) begin
    junk  <= 1'($urandom_range(0, 1));
    hv[0] <= x_valid[1]; hx[0] <= x_out[1];
    hv[1] <= hv[0];      hx[1] <= hx[0];
    hv[2] <= hv[1];      hx[2] <= hx[1];
  end
  assign f_in[0] = x_valid[0] ? F[0][x_out[0]] : junk;
  assign f_in[1] = hv[2] ? F[1][hx[2]] : junk;

  typedef struct {
    int           d;
    logic [127:0] tt;
    logic [7:0]   ones;
    int           vcyc;
    int           hold;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] popcnt(input logic [127:0] f);
    logic [7:0] n = 8'd0;
    for (int k = 0; k < 128; k++) if (f[k]) n++;
    return n;
  endfunction

  // Monitor / consumer: pops expectations when a result appears, checks it,
  // holds tt_ready low for the requested time while checking stability.
  bit           seen [2];
  int           hold_cnt [2];
  int           done_cnt [2];
  logic [127:0] snap_tt [2];
  logic [7:0]   snap_ones [2];
  initial begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      seen[d] = 0; hold_cnt[d] = 0; done_cnt[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (tt_valid[d] === 1'b1) begin
          if (!seen[d]) begin
            if (q.size() == 0) begin
              chk("spurious_valid", 128'(d), 128'(-1));
            end else begin
              e = q.pop_front();
              chk("dut_id", 128'(d), 128'(e.d));
              chk("tt", tt[d], e.tt);
              chk("ones", 128'(ones[d]), 128'(e.ones));
              chk("valid_cycle", 128'(cyc), 128'(e.vcyc));
              hold_cnt[d] = e.hold;
            end
            seen[d] = 1;
            snap_tt[d] = tt[d];
            snap_ones[d] = ones[d];
          end else begin
            chk("hold_stable", {ones[d], tt[d][119:0]}, {snap_ones[d], snap_tt[d][119:0]});
            chk("hold_stable_hi", 128'(tt[d][127:120]), 128'(snap_tt[d][127:120]));
          end
          if (hold_cnt[d] == 0) tt_ready[d] = 1'b1;
          else hold_cnt[d]--;
        end else if (seen[d]) begin
          tt_ready[d] = 1'b0;
          seen[d] = 0;
          done_cnt[d]++;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic launch(input int d, input logic [127:0] f, input int hold);
    exp_t e;
    F[d]   = f;
    e.d    = d;
    e.tt   = f;
    e.ones = popcnt(f);
    e.vcyc = (cyc + 1) + 128 + ((d == 1) ? 3 : 0);
    e.hold = hold;
    q.push_back(e);
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    chk("first_vec", 128'({x_valid[d], busy[d], x_out[d]}), 128'({1'b1, 1'b1, 7'd0}));
  endtask

  task automatic wait_done(input int d, input int n0, input bit hold_start);
    int t = 0;
    while (done_cnt[d] == n0 && t < 400) begin
      if (hold_start && tt_valid[d]) start[d] = 1'b1;
      tick();
      t++;
    end
    start[d] = 1'b0;
    if (done_cnt[d] == n0) chk("done_timeout", 128'(t), 128'(0));
  endtask

  task automatic run_sweep(input int d, input logic [127:0] f, input int hold, input bit poke);
    int n0 = done_cnt[d];
    bit idle_ok = 1;
    launch(d, f, hold);
    if (poke) begin
      repeat (20) tick();
      start[d] = 1'b1;
      tick();
      start[d] = 1'b0;
    end
    wait_done(d, n0, poke);
    if (poke) begin
      for (int i = 0; i < 5; i++) begin
        if (busy[d] !== 1'b0 || x_valid[d] !== 1'b0 || tt_valid[d] !== 1'b0) idle_ok = 0;
        if (i < 4) tick();
      end
      chk("no_extra_sweep", 128'(idle_ok), 128'(1));
    end
  endtask

  task automatic chk_reset_outs(input int d, input string name);
    chk(name, 128'({busy[d], x_valid[d], x_out[d], tt_valid[d], ones[d]}), 128'(0));
    chk({name, "_tt"}, tt[d], 128'(0));
  endtask

  task automatic reset_at_60(input int d, input logic [127:0] f);
    int t = 0;
    exp_t e;
    launch(d, f, 0);
    while (x_out[d] != 7'd60 && t < 200) begin tick(); t++; end
    chk("reach_idx60", 128'(x_out[d]), 128'(60));
    rst[d] = 1'b1;
    tick();
    rst[d] = 1'b0;
    e = q.pop_back();
    chk_reset_outs(d, "rst_mid_sweep");
    repeat (140) tick();
    chk("no_valid_after_rst", 128'(tt_valid[d]), 128'(0));
    run_sweep(d, f, 1, 0);
  endtask

  function automatic logic [127:0] rand_tt();
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    logic [127:0] f_maj, f_x6, f_and, fr;
    for (int k = 0; k < 128; k++) begin
      f_maj[k] = (k[0] & k[1]) | (k[0] & k[2]) | (k[1] & k[2]);
      f_x6[k]  = k[6];
      f_and[k] = (k == 127);
    end
    rst = 2'b11; start = 2'b00; tt_ready = 2'b00;
    F[0] = '0; F[1] = '0;
    repeat (3) tick();
    chk_reset_outs(0, "reset0");
    chk_reset_outs(1, "reset1");
    rst = 2'b00;
    tick();

    // LAT = 0 instance
    run_sweep(0, f_maj, 0, 0);
    run_sweep(0, rand_tt(), 10, 1);
    run_sweep(0, f_and, 2, 0);
    run_sweep(0, 128'(0), 0, 0);
    fr = rand_tt();
    run_sweep(0, fr, 0, 0);
    run_sweep(0, fr, 0, 0);
    reset_at_60(0, rand_tt());

    // LAT = 3 instance
    run_sweep(1, f_x6, 0, 0);
    run_sweep(1, rand_tt(), 10, 1);
    fr = rand_tt();
    run_sweep(1, fr, 0, 0);
    run_sweep(1, fr, 3, 0);
    reset_at_60(1, rand_tt());

    // Reset and start together: reset wins
    rst[1] = 1'b1; start[1] = 1'b1;
    tick();
    rst[1] = 1'b0; start[1] = 1'b0;
    chk_reset_outs(1, "rst_and_start");
    repeat (3) tick();
    chk("still_idle", 128'({busy[1], x_valid[1]}), 128'(0));

    repeat (150) tick();
    chk("queue_drained", 128'(q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
